// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core, DMA) arbiter onto one data-memory port.
// Ports: clk, reset (async active-low); core_* and dma_* request ports
// (req/we/addr/wdata in, rdata/ack out, core_stall out); mem_* memory side.
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W =
        (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_C = 3'd1,
        RESP_C  = 3'd2,
        ISSUE_D = 3'd3,
        RESP_D  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  starve_cnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              starved;
    logic              grant_c;
    logic              grant_d;
    logic              dma_busy;
    logic              issuing;
    logic              core_load;
    logic              dma_load;

    assign starved  = (starve_cnt >= LIM);
    assign grant_c  = (state == IDLE) && core_req && !starved;
    assign grant_d  = (state == IDLE) && dma_req
                      && (!core_req || starved);
    assign dma_busy = (state == ISSUE_D) || (state == RESP_D);
    assign issuing  = (state == ISSUE_C) || (state == ISSUE_D);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_c)      state_nx = ISSUE_C;
                else if (grant_d) state_nx = ISSUE_D;
            end
            ISSUE_C: state_nx = RESP_C;
            RESP_C:  state_nx = IDLE;
            ISSUE_D: state_nx = RESP_D;
            RESP_D:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant clears the counter even if dma_req would otherwise count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            starve_cnt <= '0;
        end else if (dma_req && !dma_busy && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (grant_c) begin
            cap_we    <= core_we;
            cap_addr  <= core_addr;
            cap_wdata <= core_wdata;
        end else if (grant_d) begin
            cap_we    <= dma_we;
            cap_addr  <= dma_addr;
            cap_wdata <= dma_wdata;
        end
    end

    assign core_load = (state == RESP_C) && !cap_we;
    assign dma_load  = (state == RESP_D) && !cap_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            if (core_load) core_rdata_q <= mem_rdata;
            if (dma_load)  dma_rdata_q  <= mem_rdata;
        end
    end

    // Strobes decode from state so reset drops them asynchronously.
    assign mem_rd     = issuing && !cap_we;
    assign mem_wr     = issuing && cap_we;
    assign mem_addr   = cap_addr;
    assign mem_wdata  = cap_wdata;

    assign core_ack   = (state == RESP_C);
    assign dma_ack    = (state == RESP_D);
    assign core_rdata = core_load ? mem_rdata : core_rdata_q;
    assign dma_rdata  = dma_load  ? mem_rdata : dma_rdata_q;
    assign core_stall = core_req & ~core_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a
// one-cycle-latency memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        core_ack, core_stall;
    logic        dma_req, dma_we;
    logic [8:0]  dma_addr;
    logic [31:0] dma_wdata, dma_rdata;
    logic        dma_ack;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [512];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    dmem_arbiter #(
        .DATA_W(32), .ADDR_W(9), .STARVE_LIM(4)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_ack(core_ack),
        .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 with the DUT in IDLE; leaves it in IDLE.
    task automatic run_access(input bit          is_dma,
                              input bit          we,
                              input logic [8:0]  addr,
                              input logic [31:0] wd,
                              input logic [31:0] exp_rd);
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we;
            dma_addr = addr; dma_wdata = wd;
        end else begin
            core_req = 1'b1; core_we = we;
            core_addr = addr; core_wdata = wd;
        end
        @(negedge clk);
        check("idle_rd", 32'(mem_rd), 0);
        check("idle_wr", 32'(mem_wr), 0);
        if (!is_dma) check("stall_idle", 32'(core_stall), 1);
        nxt();
        @(negedge clk);
        check("iss_rd", 32'(mem_rd), 32'(!we));
        check("iss_wr", 32'(mem_wr), 32'(we));
        check("iss_addr", 32'(mem_addr), 32'(addr));
        if (we) check("iss_wdata", mem_wdata, wd);
        if (!is_dma) check("stall_iss", 32'(core_stall), 1);
        nxt();
        @(negedge clk);
        check("resp_rd", 32'(mem_rd), 0);
        check("resp_wr", 32'(mem_wr), 0);
        if (is_dma) begin
            check("dma_ack", 32'(dma_ack), 1);
            check("core_ack0", 32'(core_ack), 0);
            if (!we) check("dma_rdata", dma_rdata, exp_rd);
        end else begin
            check("core_ack", 32'(core_ack), 1);
            check("dma_ack0", 32'(dma_ack), 0);
            check("stall_ack", 32'(core_stall), 0);
            if (!we) check("core_rdata", core_rdata, exp_rd);
        end
        nxt();
        dma_req  = 1'b0;
        core_req = 1'b0;
        @(negedge clk);
        check("ack_pulse", 32'(core_ack | dma_ack), 0);
        nxt();
    endtask

    localparam logic [3:0] TBL [9] = '{
        4'b0000, 4'b1000, 4'b0010,
        4'b0000, 4'b1000, 4'b0010,
        4'b0000, 4'b0100, 4'b0001
    };

    initial begin
        reset = 1'b1;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        #3 reset = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        check("rst_state", 32'(dut.state), 0);
        check("rst_cnt", 32'(dut.starve_cnt), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_wr", 32'(mem_wr), 0);
        check("rst_cack", 32'(core_ack), 0);
        check("rst_dack", 32'(dma_ack), 0);
        check("rst_crdata", core_rdata, 0);
        check("rst_drdata", dma_rdata, 0);
        nxt();
        reset = 1'b1;

        run_access(0, 1, 9'h005, 32'hDEAD_BEEF, 0);
        run_access(0, 0, 9'h005, 0, 32'hDEAD_BEEF);
        @(negedge clk);
        check("rdata_hold", core_rdata, 32'hDEAD_BEEF);
        nxt();

        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h005;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'h010;
        dma_wdata = 32'hA5A5_A5A5;
        for (int c = 0; c < 9; c++) begin
            if (c == 7) dma_addr = 9'h1FF;
            @(negedge clk);
            check("ct_rd", 32'(mem_rd), 32'(TBL[c][3]));
            check("ct_wr", 32'(mem_wr), 32'(TBL[c][2]));
            check("ct_cack", 32'(core_ack), 32'(TBL[c][1]));
            check("ct_dack", 32'(dma_ack), 32'(TBL[c][0]));
            if (c == 6) check("ct_cnt4", 32'(dut.starve_cnt), 4);
            if (c == 7) begin
                check("ct_addr", 32'(mem_addr), 32'h010);
                check("ct_cnt0", 32'(dut.starve_cnt), 0);
            end
            nxt();
        end
        core_req = 1'b0;
        dma_req  = 1'b0;
        @(negedge clk);
        check("ct_mem", mem[9'h010], 32'hA5A5_A5A5);
        nxt();
        @(negedge clk);
        check("drop_rd", 32'(mem_rd), 0);
        check("drop_wr", 32'(mem_wr), 0);
        check("drop_state", 32'(dut.state), 0);
        nxt();

        run_access(1, 1, 9'h1FF, 32'h1234_5678, 0);
        run_access(0, 1, 9'h000, 32'hCAFE_F00D, 0);
        run_access(1, 0, 9'h1FF, 0, 32'h1234_5678);
        run_access(0, 0, 9'h000, 0, 32'hCAFE_F00D);

        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h000;
        nxt();
        @(negedge clk);
        check("mid_rd", 32'(mem_rd), 1);
        #1 reset = 1'b0;
        #1;
        check("abort_rd", 32'(mem_rd), 0);
        check("abort_wr", 32'(mem_wr), 0);
        nxt();
        @(negedge clk);
        check("abort_ack", 32'(core_ack), 0);
        nxt();
        core_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_state", 32'(dut.state), 0);
        check("post_rdata", core_rdata, 0);
        check("post_ack", 32'(core_ack), 0);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 9, giving the data-memory word address width.
REQ-003 The block SHALL have parameter STARVE_LIM, default 4, giving the DMA wait-cycle limit before DMA overrides core priority.
REQ-004 The block SHALL have a single clock and asynchronous active-low reset:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
REQ-005 The block SHALL have these core port signals:
- core_req  in  1  load/store request
- core_we  in  1  1=store, 0=load
- core_addr  in  ADDR_W  word address
- core_wdata  in  DATA_W  store data
- core_rdata  out  DATA_W  load data
- core_ack  out  1  one-cycle completion pulse
- core_stall  out  1  pipeline freeze request
REQ-006 The block SHALL have these DMA port signals:
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack, with the same directions, widths and meanings as the core port.
REQ-007 The block SHALL have these memory-side signals:
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd

Function
REQ-008 The FSM SHALL have states IDLE, ISSUE_C, RESP_C, ISSUE_D and RESP_D.
REQ-009 Arbitration SHALL occur only in IDLE.
- Core wins if core_req=1 and starve_cnt<STARVE_LIM.
- DMA wins if dma_req=1 and (core_req=0 or starve_cnt>=STARVE_LIM).
- With no request, the FSM remains in IDLE.
REQ-010 On a grant, the winner's we, addr and wdata SHALL be captured into internal registers, and requester changes after the grant SHALL have no effect on that access.
REQ-011 ISSUE_x SHALL last one cycle and drive:
- mem_addr and mem_wdata from the captured registers;
- mem_wr=captured we, mem_rd=~captured we.
ISSUE_x SHALL then go to RESP_x.
REQ-012 RESP_x SHALL last one cycle, assert x_ack=1 and go to IDLE.
- x_rdata = mem_rdata in RESP_x for loads.
- Outside RESP_x, x_rdata SHALL hold the last loaded value.
REQ-013 Latency SHALL be: request seen in IDLE at cycle N gives mem strobe at N+1 and ack at N+2, with a 3-cycle minimum spacing between accesses.
REQ-014 mem_rd and mem_wr SHALL both be 0 in IDLE and RESP_x, and SHALL never both be 1.
REQ-015 core_stall SHALL equal core_req & ~core_ack (combinational).
REQ-016 starve_cnt SHALL be ceil(log2(STARVE_LIM+1)) bits wide and behave as follows:
- increments each cycle dma_req=1 and state is not ISSUE_D or RESP_D;
- saturates at STARVE_LIM;
- clears to 0 on a DMA grant;
- holds when dma_req=0.
REQ-017 The requester handshake SHALL follow these rules:
- Requesters hold req and the request fields stable until ack.
- Requesters may drop req the cycle after ack.
- A req held high after ack SHALL be treated as a new request at the next IDLE.
REQ-018 Simultaneous core_req and dma_req with starve_cnt<STARVE_LIM SHALL grant the core, and the DMA waits.
REQ-019 A request deasserted before its grant SHALL be silently dropped, with no memory access.

Reset
REQ-020 While reset=0, the block SHALL set:
- state=IDLE, starve_cnt=0;
- all captured registers, core_rdata and dma_rdata to 0;
- mem_rd, mem_wr, core_ack and dma_ack to 0.
REQ-021 Reset asserted mid-access SHALL abort it immediately, with the strobe deasserted asynchronously and no ack issued.
REQ-022 After reset release, the first arbitration SHALL occur on the first rising edge with reset=1.

Verification
REQ-023 Core store: core_req=1, we=1, addr=0x05, wdata=0xDEADBEEF -> next cycle mem_wr=1, mem_addr=0x05, mem_wdata=0xDEADBEEF; following cycle core_ack=1; core_stall=1 on the two cycles before ack.
REQ-024 Core load after that store: addr=0x05 with memory model returning stored data -> core_ack with core_rdata=0xDEADBEEF, mem_wr=0 throughout.
REQ-025 Contention: core_req and dma_req held continuously, STARVE_LIM=4 -> core served first; DMA granted no later than the IDLE where starve_cnt reaches 4; starve_cnt=0 after DMA grant.
REQ-026 Field change after grant: dma_addr changed 0x10->0x1FF during ISSUE_D -> mem_addr stays 0x10.
REQ-027 Reset mid-access: reset=0 during ISSUE_C -> mem_rd/mem_wr drop immediately; no core_ack; after release core_rdata=0 and state IDLE.
REQ-028 Address wrap/boundary: DMA load from 0x1FF, then core load from 0x000 -> correct data on each; no strobe asserted in any IDLE cycle.
